// File: rtl/counter_pkg.sv
// Shared types and bound arithmetic for the counter family.
// Values are carried one bit wider than the widest counter, so bound tests never wrap.
package counter_pkg;

    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W:0] cnt_ext_t;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_CLEAR,
        CNT_LOAD,
        CNT_UP,
        CNT_DOWN
    } cnt_op_t;

    typedef struct packed {
        cnt_ext_t next;
        logic     ovf;
        logic     unf;
    } bound_t;

    function automatic cnt_ext_t clamp(input cnt_ext_t value, input cnt_ext_t lo, input cnt_ext_t hi);
        cnt_ext_t r;
        r = value;
        if (value < lo) begin
            r = lo;
        end else if (value > hi) begin
            r = hi;
        end
        return r;
    endfunction

    // One step up or down from value; the crossing tests use the extra top bit.
    function automatic bound_t bound_check(
        input cnt_ext_t value,
        input cnt_ext_t step,
        input logic     is_up,
        input cnt_ext_t lo,
        input cnt_ext_t hi,
        input cnt_ext_t up_wrap,
        input cnt_ext_t dn_wrap,
        input logic     saturate
    );
        bound_t r;
        r.ovf  = 1'b0;
        r.unf  = 1'b0;
        r.next = value;
        if (is_up) begin
            if (value + step > hi) begin
                r.ovf  = 1'b1;
                r.next = saturate ? hi : up_wrap;
            end else begin
                r.next = value + step;
            end
        end else begin
            if (value < lo + step) begin
                r.unf  = 1'b1;
                r.next = saturate ? lo : dn_wrap;
            end else begin
                r.next = value - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_updn.sv
// Up/down counter with programmable bounds, step, clamped load and wrap-or-saturate.
// Count and the overflow/underflow pulses are all registered.
module counter_updn
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned MIN_VALUE       = 0,
    parameter int unsigned MAX_VALUE       = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned RESET_VALUE     = MIN_VALUE,
    parameter int unsigned UP_WRAP_VALUE   = MIN_VALUE,
    parameter int unsigned DOWN_WRAP_VALUE = MAX_VALUE,
    parameter int unsigned STEP            = 1,
    parameter bit          SATURATE        = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             at_max,
    output logic             at_min
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
        $error("counter_updn: WIDTH must be in [1, %0d]", CNT_MAX_W);
    end
    if (64'(MAX_VALUE) >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("counter_updn: MAX_VALUE does not fit in WIDTH bits");
    end
    if (MIN_VALUE > RESET_VALUE || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
        $error("counter_updn: RESET_VALUE outside [MIN_VALUE, MAX_VALUE]");
    end
    if (UP_WRAP_VALUE < MIN_VALUE || UP_WRAP_VALUE > MAX_VALUE ||
        DOWN_WRAP_VALUE < MIN_VALUE || DOWN_WRAP_VALUE > MAX_VALUE) begin : g_bad_wrap
        $error("counter_updn: wrap values outside [MIN_VALUE, MAX_VALUE]");
    end
    if (STEP < 1 || MAX_VALUE < MIN_VALUE || STEP > MAX_VALUE - MIN_VALUE) begin : g_bad_step
        $error("counter_updn: STEP must be in [1, MAX_VALUE - MIN_VALUE]");
    end

    localparam cnt_ext_t MIN_X  = cnt_ext_t'(MIN_VALUE);
    localparam cnt_ext_t MAX_X  = cnt_ext_t'(MAX_VALUE);
    localparam cnt_ext_t UPW_X  = cnt_ext_t'(UP_WRAP_VALUE);
    localparam cnt_ext_t DNW_X  = cnt_ext_t'(DOWN_WRAP_VALUE);
    localparam cnt_ext_t STEP_X = cnt_ext_t'(STEP);

    localparam logic [WIDTH-1:0] MIN_W   = MIN_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_W   = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    cnt_op_t          op;
    bound_t           bc;
    cnt_ext_t         load_clamped;
    logic             unused_hi;

    always_comb begin
        op = CNT_HOLD;
        if (clear) begin
            op = CNT_CLEAR;
        end else if (load) begin
            op = CNT_LOAD;
        end else if (enable) begin
            op = up_dn ? CNT_UP : CNT_DOWN;
        end

        load_clamped = clamp(cnt_ext_t'(load_value), MIN_X, MAX_X);
        bc = bound_check(cnt_ext_t'(count_q), STEP_X, op == CNT_UP,
                         MIN_X, MAX_X, UPW_X, DNW_X, SATURATE);

        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        case (op)
            CNT_CLEAR: count_d = RESET_W;
            CNT_LOAD:  count_d = load_clamped[WIDTH-1:0];
            CNT_UP, CNT_DOWN: begin
                count_d     = bc.next[WIDTH-1:0];
                overflow_d  = bc.ovf;
                underflow_d = bc.unf;
            end
            default: ;
        endcase
    end

    // The results never exceed MAX_VALUE, so bits above WIDTH are always zero.
    assign unused_hi = ^{bc.next[CNT_MAX_W:WIDTH], load_clamped[CNT_MAX_W:WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= RESET_W;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign at_max    = (count_q == MAX_W);
    assign at_min    = (count_q == MIN_W);

endmodule

// File: tb/tb_counter_updn.sv
// Bench for counter_updn: wrap config, saturate config and a two-stage decimal cascade.
module tb_counter_updn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // wrap configuration: MIN 10, MAX 20, RESET 12, STEP 1
    logic       b_clear, b_enable, b_up_dn, b_load;
    logic [7:0] b_load_value, b_count;
    logic       b_ovf, b_unf, b_at_max, b_at_min;

    // saturate configuration: same bounds, STEP 3
    logic       s_clear, s_enable, s_up_dn, s_load;
    logic [7:0] s_load_value, s_count;
    logic       s_ovf, s_unf, s_at_max, s_at_min;

    // cascade: two 0..9 counters
    logic       c_enable;
    logic [3:0] c_lo_count, c_hi_count;
    logic       c_lo_ovf, c_lo_unf, c_lo_at_max, c_lo_at_min;
    logic       c_hi_ovf, c_hi_unf, c_hi_at_max, c_hi_at_min;

    counter_updn #(.WIDTH(8), .MIN_VALUE(10), .MAX_VALUE(20), .RESET_VALUE(12),
                   .UP_WRAP_VALUE(10), .DOWN_WRAP_VALUE(20), .STEP(1), .SATURATE(1'b0)) u_base (
        .clk(clk), .reset_n(reset_n), .clear(b_clear), .enable(b_enable), .up_dn(b_up_dn),
        .load(b_load), .load_value(b_load_value), .count(b_count), .overflow(b_ovf),
        .underflow(b_unf), .at_max(b_at_max), .at_min(b_at_min));

    counter_updn #(.WIDTH(8), .MIN_VALUE(10), .MAX_VALUE(20), .RESET_VALUE(12),
                   .UP_WRAP_VALUE(10), .DOWN_WRAP_VALUE(20), .STEP(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(s_clear), .enable(s_enable), .up_dn(s_up_dn),
        .load(s_load), .load_value(s_load_value), .count(s_count), .overflow(s_ovf),
        .underflow(s_unf), .at_max(s_at_max), .at_min(s_at_min));

    counter_updn #(.WIDTH(4), .MIN_VALUE(0), .MAX_VALUE(9), .RESET_VALUE(0),
                   .UP_WRAP_VALUE(0), .DOWN_WRAP_VALUE(9), .STEP(1), .SATURATE(1'b0)) u_lo (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(c_enable), .up_dn(1'b1),
        .load(1'b0), .load_value(4'd0), .count(c_lo_count), .overflow(c_lo_ovf),
        .underflow(c_lo_unf), .at_max(c_lo_at_max), .at_min(c_lo_at_min));

    counter_updn #(.WIDTH(4), .MIN_VALUE(0), .MAX_VALUE(9), .RESET_VALUE(0),
                   .UP_WRAP_VALUE(0), .DOWN_WRAP_VALUE(9), .STEP(1), .SATURATE(1'b0)) u_hi (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .enable(c_lo_ovf), .up_dn(1'b1),
        .load(1'b0), .load_value(4'd0), .count(c_hi_count), .overflow(c_hi_ovf),
        .underflow(c_hi_unf), .at_max(c_hi_at_max), .at_min(c_hi_at_min));

    // scoreboard: {count[7:0], ovf, unf, at_max, at_min}
    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int bm_count, sm_count, cm_lo, cm_hi;
    bit bm_ovf, bm_unf, sm_ovf, sm_unf, cm_lo_ovf, cm_lo_unf, cm_hi_ovf, cm_hi_unf;

    // Reference behaviour of one counter for one clock edge.
    task automatic model_step(input int lo, input int hi, input int rst, input int upw,
                              input int dnw, input int stp, input bit sat,
                              input bit clr, input bit ld, input int lv, input bit en,
                              input bit ud, inout int c, output bit o, output bit u);
        o = 1'b0;
        u = 1'b0;
        if (clr) begin
            c = rst;
        end else if (ld) begin
            c = (lv < lo) ? lo : ((lv > hi) ? hi : lv);
        end else if (en) begin
            if (ud) begin
                if (c + stp > hi) begin
                    c = sat ? hi : upw;
                    o = 1'b1;
                end else begin
                    c = c + stp;
                end
            end else begin
                if (c - stp < lo) begin
                    c = sat ? lo : dnw;
                    u = 1'b1;
                end else begin
                    c = c - stp;
                end
            end
        end
    endtask

    task automatic drive_base(input bit clr, input bit ld, input int lv, input bit en, input bit ud);
        b_clear = clr; b_load = ld; b_load_value = 8'(lv); b_enable = en; b_up_dn = ud;
        model_step(10, 20, 12, 10, 20, 1, 1'b0, clr, ld, lv, en, ud, bm_count, bm_ovf, bm_unf);
        exp_q.push_back({8'(bm_count), bm_ovf, bm_unf, bm_count == 20, bm_count == 10});
        @(posedge clk);
        #1;
        b_clear = 0; b_load = 0; b_enable = 0; b_up_dn = 0; b_load_value = 0;
    endtask

    task automatic drive_sat(input bit clr, input bit ld, input int lv, input bit en, input bit ud);
        s_clear = clr; s_load = ld; s_load_value = 8'(lv); s_enable = en; s_up_dn = ud;
        model_step(10, 20, 12, 10, 20, 3, 1'b1, clr, ld, lv, en, ud, sm_count, sm_ovf, sm_unf);
        exp_q.push_back({8'(sm_count), sm_ovf, sm_unf, sm_count == 20, sm_count == 10});
        @(posedge clk);
        #1;
        s_clear = 0; s_load = 0; s_enable = 0; s_up_dn = 0; s_load_value = 0;
    endtask

    task automatic test_reset;
        logic [11:0] got, exp;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({b_count, b_ovf, b_unf, b_at_max, b_at_min} !== {8'd12, 4'b0000} ||
            {s_count, s_ovf, s_unf} !== {8'd12, 2'b00}) begin
            errors++;
            $display("FAIL reset_state got=%0d/%0d exp=12", b_count, s_count);
        end
        reset_n = 1'b1;
        bm_count = 12; sm_count = 12; cm_lo = 0; cm_hi = 0;
        cm_lo_ovf = 0; cm_hi_ovf = 0;
        drive_base(0, 1, 17, 0, 0);
        drive_base(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            if (i == 1) begin
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL reset_precount got=%h exp=%h", got, exp);
                end
            end
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({b_count, b_ovf, b_unf} !== {8'd12, 2'b00}) begin
            errors++;
            $display("FAIL reset_async got=%0d exp=12", b_count);
        end
        bm_count = 12; bm_ovf = 0; bm_unf = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_base(0, 0, 0, 0, 0);
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || b_count !== 8'd12) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_up_wrap;
        logic [11:0] got, exp;
        for (int i = 0; i < 12; i++) begin
            drive_base(0, 0, 0, 1, 1);
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL up_wrap cyc=%0d got=%h exp=%h", i, got, exp);
            end
            if (i == 7 || i == 8) begin
                checks++;
                if ((i == 7 && {b_count, b_ovf, b_at_max} !== {8'd20, 2'b01}) ||
                    (i == 8 && {b_count, b_ovf, b_at_max} !== {8'd10, 2'b10})) begin
                    errors++;
                    $display("FAIL up_wrap_edge cyc=%0d count=%0d ovf=%b at_max=%b", i, b_count, b_ovf, b_at_max);
                end
            end
        end
    endtask

    task automatic test_down_wrap;
        logic [11:0] got, exp;
        drive_base(0, 1, 11, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive_base(0, 0, 0, 1, 0);
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL down_wrap cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        checks++;
        if ({b_count, b_unf} !== {8'd19, 1'b0}) begin
            errors++;
            $display("FAIL down_wrap_end got=%0d exp=19", b_count);
        end
    endtask

    task automatic test_priority_clamp;
        logic [11:0] got, exp;
        int exp_c[4] = '{12, 10, 20, 15};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive_base(1, 1, 15, 1, 1);
                1: drive_base(0, 1, 5, 0, 0);
                2: drive_base(0, 1, 250, 0, 0);
                default: drive_base(0, 1, 15, 1, 1);
            endcase
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || int'(b_count) != exp_c[i]) begin
                errors++;
                $display("FAIL priority_clamp case=%0d got=%h exp=%h const=%0d", i, got, exp, exp_c[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] got, exp;
        for (int i = 0; i < 70; i++) begin
            if (i < 10) begin
                drive_base(0, 0, 0, 1, i[0]);
            end else begin
                drive_base($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                           1'($urandom_range(0, 1)));
            end
            got = {b_count, b_ovf, b_unf, b_at_max, b_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturate;
        logic [11:0] got, exp;
        int exp_c[7] = '{18, 20, 20, 12, 10, 17, 14};
        bit exp_o[7] = '{0, 1, 1, 0, 0, 0, 0};
        bit exp_u[7] = '{0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive_sat(0, 1, 18, 0, 0);
                1, 2: drive_sat(0, 0, 0, 1, 1);
                3: drive_sat(0, 1, 12, 0, 0);
                4: drive_sat(0, 0, 0, 1, 0);
                5: drive_sat(0, 1, 17, 0, 0);
                default: drive_sat(0, 0, 0, 1, 0);
            endcase
            got = {s_count, s_ovf, s_unf, s_at_max, s_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || int'(s_count) != exp_c[i] || s_ovf !== exp_o[i] || s_unf !== exp_u[i]) begin
                errors++;
                $display("FAIL saturate step=%0d got=%h exp=%h const=%0d", i, got, exp, exp_c[i]);
            end
        end
    endtask

    task automatic test_cascade;
        logic [11:0] got, exp;
        int hi_pulses = 0;
        bit hi_en;
        for (int i = 0; i < 105; i++) begin
            c_enable = (i < 100);
            hi_en = cm_lo_ovf;
            model_step(0, 9, 0, 0, 9, 1, 1'b0, 1'b0, 1'b0, 0, c_enable, 1'b1, cm_lo, cm_lo_ovf, cm_lo_unf);
            model_step(0, 9, 0, 0, 9, 1, 1'b0, 1'b0, 1'b0, 0, hi_en, 1'b1, cm_hi, cm_hi_ovf, cm_hi_unf);
            exp_q.push_back({8'(cm_lo), cm_lo_ovf, cm_lo_unf, cm_lo == 9, cm_lo == 0});
            exp_q.push_back({8'(cm_hi), cm_hi_ovf, cm_hi_unf, cm_hi == 9, cm_hi == 0});
            @(posedge clk);
            #1;
            if (c_hi_ovf) hi_pulses++;
            got = {4'd0, c_lo_count, c_lo_ovf, c_lo_unf, c_lo_at_max, c_lo_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cascade_lo cyc=%0d got=%h exp=%h", i, got, exp);
            end
            got = {4'd0, c_hi_count, c_hi_ovf, c_hi_unf, c_hi_at_max, c_hi_at_min};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cascade_hi cyc=%0d got=%h exp=%h", i, got, exp);
            end
        end
        c_enable = 1'b0;
        checks++;
        if (c_lo_count !== 4'd0 || c_hi_count !== 4'd0 || hi_pulses != 1) begin
            errors++;
            $display("FAIL cascade_end lo=%0d hi=%0d pulses=%0d exp 0 0 1", c_lo_count, c_hi_count, hi_pulses);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        b_clear = 0; b_enable = 0; b_up_dn = 0; b_load = 0; b_load_value = 0;
        s_clear = 0; s_enable = 0; s_up_dn = 0; s_load = 0; s_load_value = 0;
        c_enable = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_priority_clamp();
        test_back_to_back();
        test_saturate();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
